// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake between pc_fetch_unit (master) and the
// instruction memory (slave).
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// MIPS IF stage: PC register, imem request/ready fetch, IF/ID register with a
// one-entry stall buffer and redirect draining. Optional macro FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            next_pc,
  input  logic                   delay_slot_in,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            if_pc,
  output logic                   ifid_valid,
  output logic [31:0]            ifid_instr,
  output logic [31:0]            ifid_pc,
  output logic                   ifid_ds,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall_cycles
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] hold_instr;
  logic        hold_ds;
  logic [31:0] pending_pc;

  // Request and address depend only on registered state, never on inputs.
  assign imem.imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem.imem_addr = if_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      if_pc      <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_ds    <= 1'b0;
      hold_instr <= '0;
      hold_ds    <= 1'b0;
      pending_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) begin
            if_pc      <= redirect_pc;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_ds    <= 1'b0;
          end
        end
        FETCH: begin
          if (redirect) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_ds    <= 1'b0;
            if (imem.imem_ready) begin
              if_pc <= redirect_pc;
            end else begin
              pending_pc <= redirect_pc;
              state      <= DRAIN;
            end
          end else if (imem.imem_ready) begin
            if (!stall) begin
              ifid_valid <= 1'b1;
              ifid_instr <= imem.imem_rdata;
              ifid_pc    <= if_pc;
              ifid_ds    <= delay_slot_in;
              if_pc      <= next_pc;
            end else begin
              hold_instr <= imem.imem_rdata;
              hold_ds    <= delay_slot_in;
              state      <= HOLD;
            end
          end else if (!stall) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
          end
        end
        HOLD: begin
          if (redirect) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_ds    <= 1'b0;
            if_pc      <= redirect_pc;
            state      <= FETCH;
          end else if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_instr <= hold_instr;
            ifid_pc    <= if_pc;
            ifid_ds    <= hold_ds;
            if_pc      <= next_pc;
            state      <= FETCH;
          end
        end
        DRAIN: begin
          // The in-flight beat belongs to the abandoned path; wait it out, then jump.
          ifid_valid <= 1'b0;
          ifid_instr <= '0;
          ifid_ds    <= 1'b0;
          if (imem.imem_ready) begin
            if_pc <= redirect ? redirect_pc : pending_pc;
            state <= FETCH;
          end else if (redirect) begin
            pending_pc <= redirect_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        load_valid;
  logic [31:0] fetched_cnt;
  logic [31:0] stall_cnt;

  assign load_valid = !redirect && !stall &&
                      (((state == FETCH) && imem.imem_ready) || (state == HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (load_valid) fetched_cnt <= fetched_cnt + 32'd1;
      if (stall)      stall_cnt   <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetched      = fetched_cnt;
  assign perf_stall_cycles = stall_cnt;
`else
  assign perf_fetched      = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the architectural PC register, consumes the combinational next-PC and delay-slot result computed for the current PC, and issues fetches to instruction memory over a request/ready handshake. It delivers fetched words into the IF/ID pipeline register, with stall buffering, and handles exception/ERET redirects, including a fetch that is still in flight.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- next_pc  in  32  next PC for the current `if_pc` (PC+4, branch, jump or jr target).
- delay_slot_in  in  1  marks the instruction at `if_pc` as a branch delay slot.
- stall  in  1  ID stage cannot accept a new instruction.
- redirect  in  1  exception/ERET redirect; highest priority.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals the address of the outstanding request.
- imem_ready  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- if_pc  out  32  current PC register; feeds next-PC logic.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  IF/ID instruction; 0 (NOP) when invalid.
- ifid_pc  out  32  IF/ID instruction address.
- ifid_ds  out  1  IF/ID delay-slot flag.
- perf_fetched  out  32  count of instructions handed to ID (see Configuration).
- perf_stall_cycles  out  32  count of cycles with `stall` high (see Configuration).

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. Reset enters IDLE.
- IDLE
  - `imem_req`=0.
  - Unconditionally moves to FETCH on the next edge.
- FETCH
  - `imem_req`=1, `imem_addr`=`if_pc`; the address stays stable until `imem_ready`.
  - `imem_ready` & !stall & !redirect:
    - IF/ID loads {valid=1, instr=`imem_rdata`, pc=`if_pc`, ds=`delay_slot_in`}.
    - `if_pc`<=`next_pc`; state stays FETCH.
  - `imem_ready` & stall & !redirect:
    - `imem_rdata` and `delay_slot_in` are captured into a one-entry hold buffer.
    - IF/ID is unchanged; go to HOLD.
  - !`imem_ready` & stall: IF/ID is unchanged.
  - !`imem_ready` & !stall: IF/ID valid<=0 and instr<=0 (bubble).
- HOLD
  - `imem_req`=0.
  - While stall, the buffer and IF/ID are held.
  - On !stall: IF/ID loads the buffer (pc=`if_pc`), `if_pc`<=`next_pc`, go to FETCH.
- Redirect (priority over stall and ready):
  - IF/ID is always cleared (valid=0, instr=0, ds=0).
  - FETCH with `imem_ready`=1: the returning beat is discarded, `if_pc`<=`redirect_pc`, stay FETCH.
  - FETCH with `imem_ready`=0: `redirect_pc` is latched into a pending register; go to DRAIN.
  - HOLD: the buffer is discarded, `if_pc`<=`redirect_pc`, go to FETCH.
  - DRAIN: a second redirect overwrites the pending target.
  - IDLE: `if_pc`<=`redirect_pc`.
- DRAIN
  - `imem_req`=1 at the old address until `imem_ready`.
  - The beat is discarded, `if_pc`<=pending target, go to FETCH.
  - IF/ID stays invalid throughout.
- Stall does not affect DRAIN progress.
- PC arithmetic is 32-bit and wraps modulo 2^32; word alignment is the next-PC source's responsibility.

## Timing
- Reset values:
  - `if_pc`=RESET_PC.
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc`=0, `ifid_ds`=0.
  - `imem_req`=0.
  - Performance counters=0.
  - State IDLE.
- `imem_req` and `imem_addr` are combinational from state and `if_pc` only; there is no input-to-output combinational path.
- Latency: a fetch accepted at edge N (with `imem_ready` high in the cycle before) is visible on IF/ID outputs after edge N.
- Zero-wait memory sustains one instruction per cycle.
- First request is asserted in the cycle after the first post-reset edge.
- Asynchronous reset mid-fetch or mid-DRAIN abandons the transaction. Memory must tolerate a dropped request.

## Configuration
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - `perf_fetched` increments on every IF/ID load with valid=1.
  - `perf_stall_cycles` increments every cycle `stall`=1.
  - Both are 32-bit, wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are generated.

## Test plan
- Reset, zero-wait memory, `next_pc`=`if_pc`+4 -> `imem_addr` 0x3000, 0x3004, 0x3008 on consecutive cycles; `ifid_pc` follows one cycle later with valid=1.
- Memory ready after 3 wait cycles at 0x3000 -> `imem_addr` held at 0x3000 for 4 cycles and IF/ID invalid; then `ifid_instr`=returned word.
- Stall raised in the ready cycle and held 2 cycles -> HOLD state with `imem_req`=0 and IF/ID unchanged; on release IF/ID=buffered word and `if_pc` advances once.
- Redirect to 0x0000_4180 while a fetch at 0x3010 is pending -> request stays at 0x3010 until ready, the beat is discarded, next `imem_addr`=0x4180, IF/ID invalid throughout.
- `delay_slot_in`=1 at handover of 0x3008 -> `ifid_ds`=1 for that instruction only.
- With FETCH_PERF_CNT_EN: 10 fetches plus 4 stall cycles -> `perf_fetched`=10, `perf_stall_cycles`=4. Without the macro: both read 0.
